// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, instruction memory write port and core control out
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              reload;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;
  modport master (
    output in_valid, in_data, reload,
    input  in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err
  );
  modport slave (
    input  in_valid, in_data, reload,
    output in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: loads a length/payload/checksum framed image into instruction memory, holding the core in reset until verified
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  program_loader_if.slave  bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(1) << ADDR_W;
  typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERR} state_t;
  state_t             state;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  sum;
  logic               acc;
  assign bus.in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
  assign acc = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= LEN;
      len           <= '0;
      count         <= '0;
      sum           <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.core_rst  <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        LEN: if (acc) begin
          len   <= (bus.in_data == '0) ? FULL : CNT_W'(bus.in_data);
          count <= '0;
          sum   <= '0;
          state <= DATA;
        end
        DATA: if (acc) begin
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= count[ADDR_W-1:0];
          bus.mem_wdata <= bus.in_data;
          sum           <= sum + bus.in_data;
          count         <= count + 1'b1;
          state         <= (count == len - 1'b1) ? CSUM : DATA;
        end
        CSUM: if (acc) begin
          state        <= (bus.in_data == sum) ? DONE : ERR;
          bus.done     <= (bus.in_data == sum);
          bus.err      <= (bus.in_data != sum);
          bus.core_rst <= (bus.in_data != sum);
        end
        DONE, ERR: if (bus.reload) begin
          state        <= LEN;
          count        <= '0;
          sum          <= '0;
          bus.core_rst <= 1'b1;
          bus.done     <= 1'b0;
          bus.err      <= 1'b0;
        end
        default: state <= LEN;
      endcase
    end
  end
endmodule
